// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module   : hazard_stall_controller
// Brief    : Load-use stall, multi-cycle EX hold and taken-branch flush control
//            for a 5-stage MIPS pipe. Optional HAZARD_PERF_CNT_EN adds stall_cycles.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             mc_start,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] stall_cycles
`else
    output logic             IF_ID_Flush
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam bit         c_MC_EN    = (MC_LATENCY >= 2);
    localparam logic [7:0] c_CNT_INIT = c_MC_EN ? 8'(MC_LATENCY - 2) : 8'd0;

    if (MC_LATENCY < 1 || MC_LATENCY > 255 || CNT_W < 1) begin : g_param_check
        $error("hazard_stall_controller: MC_LATENCY must be 1..255 and CNT_W >= 1");
    end

    state_t     r_state, w_next_state;
    logic [7:0] r_cnt, w_next_cnt;
    logic       w_lu;

    assign w_lu = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                  ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                   (ID_EX_RegisterRt == IF_ID_RegisterRt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        IF_ID_Flush   = 1'b0;

        if (!rst_n) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (r_state == MC_BUSY && r_cnt != 8'd0) begin
            // EX still owns the mc op: freeze the front end, branch is not yet real
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            w_next_cnt    = r_cnt - 8'd1;
        end else begin
            // RUN, or the MC_BUSY release cycle where a new mc_start is not accepted
            if (branch_taken) begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (mc_start && c_MC_EN && r_state == RUN) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
                w_next_state  = MC_BUSY;
                w_next_cnt    = c_CNT_INIT;
            end else if (w_lu) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
            if (r_state == MC_BUSY) begin
                w_next_state = RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: stimulus queues expected control vectors, a monitor pops and compares at negedge.
`default_nettype none

module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mr = 1'b0;
    logic [4:0] ex_rt = 5'd0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       mc = 1'b0;
    logic       br = 1'b0;
    logic       pcw, ifw, idw, idb, exb, fl;

    // {PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush}
    localparam logic [5:0] E_RUN  = 6'b111000;
    localparam logic [5:0] E_RST  = 6'b000100;
    localparam logic [5:0] E_LU   = 6'b001100;
    localparam logic [5:0] E_HOLD = 6'b000010;
    localparam logic [5:0] E_BR   = 6'b111101;

    typedef struct {
        string      name;
        logic [5:0] ctl;
        int         cnt;
        int         sat;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    m_cnt = 0;
    int    m_sat = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [1:0]  sat_cycles;
    logic        s_pcw, s_ifw, s_idw, s_idb, s_exb, s_fl;

    hazard_stall_controller #(.MC_LATENCY(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(ex_rt),
        .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt), .mc_start(mc),
        .branch_taken(br), .PCWrite(s_pcw), .IF_ID_Write(s_ifw), .ID_EX_Write(s_idw),
        .ID_EX_Bubble(s_idb), .EX_MEM_Bubble(s_exb), .IF_ID_Flush(s_fl),
        .stall_cycles(sat_cycles)
    );
`endif

    hazard_stall_controller #(.MC_LATENCY(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(ex_rt),
        .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt), .mc_start(mc),
        .branch_taken(br), .PCWrite(pcw), .IF_ID_Write(ifw), .ID_EX_Write(idw),
        .ID_EX_Bubble(idb), .EX_MEM_Bubble(exb),
`ifdef HAZARD_PERF_CNT_EN
        .IF_ID_Flush(fl), .stall_cycles(stall_cycles)
`else
        .IF_ID_Flush(fl)
`endif
    );

    // One vector per cycle: inputs change just after the rising edge.
    task automatic drive(input string nm, input logic i_mr, input logic [4:0] i_ex_rt,
                         input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_mc,
                         input logic i_br, input logic i_rstn, input logic [5:0] exp_ctl);
        item_t it;
        @(posedge clk);
        #1;
        mr = i_mr; ex_rt = i_ex_rt; id_rs = i_rs; id_rt = i_rt;
        mc = i_mc; br = i_br; rst_n = i_rstn;
        if (!i_rstn) begin
            m_cnt = 0;
            m_sat = 0;
        end
        it.name = nm; it.ctl = exp_ctl; it.cnt = m_cnt; it.sat = m_sat;
        q.push_back(it);
        if (i_rstn && !exp_ctl[5]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 3) m_sat++;
        end
    endtask

    task automatic idle(input string nm);
        drive(nm, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                checks++;
                if ({pcw, ifw, idw, idb, exb, fl} !== it.ctl) begin
                    failures++;
                    $display("FAIL %s ctl got=%b want=%b", it.name,
                             {pcw, ifw, idw, idb, exb, fl}, it.ctl);
                end
`ifdef HAZARD_PERF_CNT_EN
                checks++;
                if (stall_cycles !== 16'(it.cnt)) begin
                    failures++;
                    $display("FAIL %s stall_cycles got=%0d want=%0d", it.name, stall_cycles, it.cnt);
                end
                checks++;
                if (sat_cycles !== 2'(it.sat)) begin
                    failures++;
                    $display("FAIL %s sat_cycles got=%0d want=%0d", it.name, sat_cycles, it.sat);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        drive("reset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
        drive("reset_hold", 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, E_RST);
        idle("run_idle");

        // three load-use stalls (perf count reaches 3, 2-bit copy saturates)
        for (int i = 0; i < 3; i++) begin
            drive("lu_rs", 1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, 1'b1, E_LU);
            idle("lu_after");
        end
        drive("lu_rt", 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, E_LU);
        drive("lu_rt0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
        drive("lu_nomatch", 1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, E_RUN);
        drive("no_memread", 1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, E_RUN);

        // multi-cycle op, MC_LATENCY=4: hold T..T+2, release T+3
        drive("mc_T0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_HOLD);
        drive("mc_T1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_HOLD);
        drive("mc_T2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_HOLD);
        idle("mc_T3_release");
        idle("mc_after");

        // branch ignored while busy; release evaluates lu and ignores mc_start
        drive("mc2_T0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_HOLD);
        drive("mc2_br_ign", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, E_HOLD);
        drive("mc2_lu_ign", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, E_HOLD);
        drive("mc2_rel_lu", 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, E_LU);
        idle("mc2_no_restart");

        // branch outranks mc_start and lu, state stays RUN
        drive("br_prio", 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, E_BR);
        idle("br_after");

        // branch honoured in the release cycle
        drive("mc3_T0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_HOLD);
        drive("mc3_T1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_HOLD);
        drive("mc3_T2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_HOLD);
        drive("mc3_rel_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_BR);
        idle("mc3_after");

        // reset mid-op aborts; no leftover stall afterwards
        drive("mc4_T0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, E_HOLD);
        drive("mc4_rst", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
        idle("post_rst_0");
        idle("post_rst_1");
        drive("post_rst_lu", 1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, E_LU);
        idle("end_idle");

        for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain queue_left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
